// File: rtl/muldiv_sequencer_pkg.sv
// Shared CPU package: opcode/funct encodings plus mul/div sequencer types.
package muldiv_sequencer_pkg;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] FUNCT_MULT     = 6'h18;
  localparam logic [5:0] FUNCT_MULTU    = 6'h19;
  localparam logic [5:0] FUNCT_DIV      = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU     = 6'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on magnitudes.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  md_op_e             op_i,
  input  logic [WIDTH-1:0]   acc_hi_i,
  input  logic [WIDTH-1:0]   acc_lo_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [WIDTH-1:0]   acc_hi_o,
  output logic [WIDTH-1:0]   acc_lo_o
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_ge;

  // Multiply: conditional add then shift right; divide: shift left, trial subtract, restore.
  always_comb begin
    add_sum  = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    shifted  = {acc_hi_i, acc_lo_i[WIDTH-1]};
    sub_ge   = (shifted >= {1'b0, opnd_i});
    sub_diff = shifted[WIDTH-1:0] - opnd_i;
    acc_hi_o = acc_hi_i;
    acc_lo_o = acc_lo_i;
    if (op_i == OP_MULT) begin
      acc_hi_o = add_sum[WIDTH:1];
      acc_lo_o = {add_sum[0], acc_lo_i[WIDTH-1:1]};
    end else begin
      acc_hi_o = sub_ge ? sub_diff : shifted[WIDTH-1:0];
      acc_lo_o = {acc_lo_i[WIDTH-2:0], sub_ge};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed/unsigned multiply-divide unit with fixed latency and flush.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             op,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned DW    = 2 * WIDTH;

  md_state_e        state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [DW-1:0]    prod, prod_neg;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i     (op_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opnd_i   (opnd_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  // Operand magnitudes and full-width product with its negation.
  always_comb begin
    rs_neg   = !is_unsigned && rs_val[WIDTH-1];
    rt_neg   = !is_unsigned && rt_val[WIDTH-1];
    rs_mag   = rs_neg ? (~rs_val + WIDTH'(1)) : rs_val;
    rt_mag   = rt_neg ? (~rt_val + WIDTH'(1)) : rt_val;
    prod     = {acc_hi_q, acc_lo_q};
    prod_neg = ~prod + DW'(1);
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = md_op_e'(op);
          cnt_d     = '0;
          dbz_d     = 1'b0;
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          acc_hi_d  = '0;
          if (md_op_e'(op) == OP_DIV && rt_val == '0) begin
            state_d = DONE;
            hi_d    = rs_val;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d  = RUN;
            acc_lo_d = (md_op_e'(op) == OP_MULT) ? rt_mag : rs_mag;
            opnd_d   = (md_op_e'(op) == OP_MULT) ? rs_mag : rt_mag;
          end
        end
      end
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        state_d = DONE;
        if (op_q == OP_MULT) begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
        end else begin
          lo_d = neg_res_q ? (~acc_lo_q + WIDTH'(1)) : acc_lo_q;
          hi_d = neg_rem_q ? (~acc_hi_q + WIDTH'(1)) : acc_hi_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush cancels everything in flight and leaves visible results untouched.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic        op;
  logic        is_unsigned;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int tests_run;
  int tests_failed;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .op          (op),
    .is_unsigned (is_unsigned),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after a negedge: issues one op and observes it until done and idle.
  task automatic run_op(input logic o, input logic u, input logic [31:0] a, input logic [31:0] b,
                        output int dcyc, output int bcnt, output int dcnt,
                        output logic [31:0] h, output logic [31:0] l, output logic dz);
    dcyc = -1; bcnt = 0; dcnt = 0; h = '0; l = '0; dz = 1'b0;
    start = 1'b1; op = o; is_unsigned = u; rs_val = a; rt_val = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (dcyc < 0) begin
          dcyc = k; h = hi; l = lo; dz = div_by_zero;
        end
      end
      if (dcyc >= 0 && !busy) break;
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags got busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
    end
    tests_run++;
    if ({hi, lo} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_hilo got %h expected 0", {hi, lo});
    end
    rst_b = 1'b1;
  endtask

  task automatic test_mult();
    int dc, bc, dn; logic [31:0] h, l; logic dz;
    // First start right after reset release must be accepted.
    run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, bc, dn, h, l, dz);
    tests_run++;
    if (dc !== 34) begin tests_failed++; $display("FAIL mulu_latency got %0d expected 34", dc); end
    tests_run++;
    if (bc !== 34) begin tests_failed++; $display("FAIL mulu_busy_cycles got %0d expected 34", bc); end
    tests_run++;
    if (dn !== 1) begin tests_failed++; $display("FAIL mulu_done_pulses got %0d expected 1", dn); end
    tests_run++;
    if ({h, l} !== 64'hFFFFFFFE_00000001) begin
      tests_failed++; $display("FAIL mulu_max got %h expected fffffffe00000001", {h, l});
    end
    @(negedge clk);
    tests_run++;
    if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
      tests_failed++; $display("FAIL mulu_hold got %h expected fffffffe00000001", {hi, lo});
    end
    run_op(1'b0, 1'b0, 32'hFFFFFFF9, 32'd3, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l} !== 64'hFFFFFFFF_FFFFFFEB) begin
      tests_failed++; $display("FAIL muls_m7x3 got %h expected ffffffffffffffeb", {h, l});
    end
    run_op(1'b0, 1'b1, 32'h12345678, 32'h10, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l} !== 64'h00000001_23456780) begin
      tests_failed++; $display("FAIL mulu_shift got %h expected 0000000123456780", {h, l});
    end
    run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l} !== 64'h00000000_00000001) begin
      tests_failed++; $display("FAIL muls_m1xm1 got %h expected 0000000000000001", {h, l});
    end
    run_op(1'b0, 1'b0, 32'h80000000, 32'h80000000, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l} !== 64'h40000000_00000000) begin
      tests_failed++; $display("FAIL muls_minxmin got %h expected 4000000000000000", {h, l});
    end
  endtask

  task automatic test_div();
    int dc, bc, dn; logic [31:0] h, l; logic dz;
    run_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, dc, bc, dn, h, l, dz);
    tests_run++;
    if (dc !== 34) begin tests_failed++; $display("FAIL div_latency got %0d expected 34", dc); end
    tests_run++;
    if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD) begin
      tests_failed++; $display("FAIL divs_m7d2 got hi/lo %h expected ffffffff_fffffffd", {h, l});
    end
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l} !== 64'h00000001_FFFFFFFD) begin
      tests_failed++; $display("FAIL divs_7dm2 got hi/lo %h expected 00000001_fffffffd", {h, l});
    end
    run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l} !== 64'h00000001_7FFFFFFC) begin
      tests_failed++; $display("FAIL divu_big got hi/lo %h expected 00000001_7ffffffc", {h, l});
    end
    run_op(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l, dz} !== {64'h00000000_80000000, 1'b0}) begin
      tests_failed++; $display("FAIL divs_overflow got hi/lo/dbz %h/%b expected 00000000_80000000/0", {h, l}, dz);
    end
    run_op(1'b1, 1'b1, 32'd100, 32'd7, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l} !== 64'h00000002_0000000E) begin
      tests_failed++; $display("FAIL divu_100d7 got hi/lo %h expected 00000002_0000000e", {h, l});
    end
  endtask

  task automatic test_div_zero();
    int dc, bc, dn; logic [31:0] h, l; logic dz;
    run_op(1'b1, 1'b0, 32'd5, 32'd0, dc, bc, dn, h, l, dz);
    tests_run++;
    if (dc !== 1) begin tests_failed++; $display("FAIL dbz_latency got %0d expected 1", dc); end
    tests_run++;
    if (bc !== 1) begin tests_failed++; $display("FAIL dbz_busy_cycles got %0d expected 1", bc); end
    tests_run++;
    if ({h, l, dz} !== {64'h00000005_FFFFFFFF, 1'b1}) begin
      tests_failed++; $display("FAIL dbz_5d0 got hi/lo/dbz %h/%b expected 00000005_ffffffff/1", {h, l}, dz);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (div_by_zero !== 1'b1) begin
      tests_failed++; $display("FAIL dbz_sticky got %b expected 1", div_by_zero);
    end
    run_op(1'b1, 1'b1, 32'h80000000, 32'd0, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l, dz} !== {64'h80000000_FFFFFFFF, 1'b1}) begin
      tests_failed++; $display("FAIL dbz_unsigned got hi/lo/dbz %h/%b expected 80000000_ffffffff/1", {h, l}, dz);
    end
    run_op(1'b0, 1'b1, 32'd2, 32'd3, dc, bc, dn, h, l, dz);
    tests_run++;
    if ({h, l, dz} !== {64'h00000000_00000006, 1'b0}) begin
      tests_failed++; $display("FAIL dbz_clear got hi/lo/dbz %h/%b expected 00000000_00000006/0", {h, l}, dz);
    end
  endtask

  task automatic test_flush();
    int dc, bc, dn, dcount, bcount; logic [31:0] h, l; logic dz;
    run_op(1'b0, 1'b1, 32'd3, 32'd4, dc, bc, dn, h, l, dz);
    start = 1'b1; op = 1'b1; is_unsigned = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 10; k++) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_busy got %b expected 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_busy got %b expected 0", busy); end
    dcount = 0; bcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dcount++;
      if (busy) bcount++;
    end
    tests_run++;
    if (dcount + bcount !== 0) begin
      tests_failed++; $display("FAIL flush_no_done got done/busy cycles %0d/%0d expected 0/0", dcount, bcount);
    end
    tests_run++;
    if ({hi, lo} !== 64'h00000000_0000000C) begin
      tests_failed++; $display("FAIL flush_hold got %h expected 000000000000000c", {hi, lo});
    end
    // Flush and start together: start must not be accepted.
    flush = 1'b1; start = 1'b1; op = 1'b0; rs_val = 32'd2; rt_val = 32'd2;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL flush_start_busy got %b expected 0", busy); end
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    tests_run++;
    if (dcount !== 0 || {hi, lo} !== 64'h00000000_0000000C) begin
      tests_failed++; $display("FAIL flush_start_result got done=%0d hilo=%h expected 0/000000000000000c", dcount, {hi, lo});
    end
  endtask

  task automatic test_start_while_busy();
    int dcyc, dcount; logic [63:0] mid, res; logic dz;
    dcyc = -1; dcount = 0; mid = '0; res = '0; dz = 1'b1;
    start = 1'b1; op = 1'b0; is_unsigned = 1'b1; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 5 || k == 20 || k == 33) begin
        start = 1'b1; op = 1'b1; rs_val = 32'd9; rt_val = 32'd0;
      end else begin
        start = 1'b0;
      end
      if (k == 10) mid = {hi, lo};
      if (done) begin
        dcount++;
        if (dcyc < 0) begin dcyc = k; res = {hi, lo}; dz = div_by_zero; end
      end
    end
    start = 1'b0;
    tests_run++;
    if (mid !== 64'h00000000_0000000C) begin
      tests_failed++; $display("FAIL busy_hilo_hold got %h expected 000000000000000c", mid);
    end
    tests_run++;
    if (dcyc !== 34 || dcount !== 1) begin
      tests_failed++; $display("FAIL busy_ignore_timing got done cycle %0d pulses %0d expected 34/1", dcyc, dcount);
    end
    tests_run++;
    if ({res, dz} !== {64'h00000000_0000001E, 1'b0}) begin
      tests_failed++; $display("FAIL busy_ignore_result got %h/%b expected 000000000000001e/0", res, dz);
    end
  endtask

  task automatic test_reset_mid();
    int dc, bc, dn, dcount, bcount; logic [31:0] h, l; logic dz;
    start = 1'b1; op = 1'b0; is_unsigned = 1'b1; rs_val = 32'd7; rt_val = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 20; k++) @(negedge clk);
    rst_b = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'h0) begin
      tests_failed++; $display("FAIL reset_mid got busy/done/dbz/hi/lo=%b%b%b/%h expected all zero", busy, done, div_by_zero, {hi, lo});
    end
    @(negedge clk);
    rst_b = 1'b1;
    dcount = 0; bcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dcount++;
      if (busy) bcount++;
    end
    tests_run++;
    if (dcount + bcount !== 0) begin
      tests_failed++; $display("FAIL reset_mid_no_done got done/busy cycles %0d/%0d expected 0/0", dcount, bcount);
    end
    run_op(1'b0, 1'b0, 32'd6, 32'd7, dc, bc, dn, h, l, dz);
    tests_run++;
    if (dc !== 34 || {h, l} !== 64'h00000000_0000002A) begin
      tests_failed++; $display("FAIL reset_mid_recover got cycle %0d result %h expected 34/000000000000002a", dc, {h, l});
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_b = 1'b0; start = 1'b0; op = 1'b0; is_unsigned = 1'b0;
    rs_val = '0; rt_val = '0; flush = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_start_while_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
